// File: rtl/pwm_pkg.sv
// Shared types and defaults for the PWM generator/capture pair.
package pwm_pkg;

  localparam int PWM_INTERVAL = 1200;

  typedef enum logic [1:0] {
    WAIT  = 2'd0,
    HIGH  = 2'd1,
    LOW   = 2'd2,
    STUCK = 2'd3
  } cap_state_t;

endpackage

// File: rtl/pwm_sync.sv
// Input conditioning for pwm_capture: 2-flop synchronizer, optional glitch
// filter (PWM_CAPTURE_GLITCH_FILTER_EN) and rise/fall detection.
module pwm_sync (
  input  logic clk,
  input  logic rst,
  input  logic pwm_in,
  output logic s,
  output logic rise,
  output logic fall
);

  logic [1:0] sync;
  logic       prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= 2'b00;
    else     sync <= {sync[0], pwm_in};
  end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  localparam int WARM = 4;
  logic pend;

  // s follows the synchronized input only after two consecutive differing samples
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s    <= 1'b0;
      pend <= 1'b0;
    end else if (sync[1] != s) begin
      if (pend) begin
        s    <= sync[1];
        pend <= 1'b0;
      end else begin
        pend <= 1'b1;
      end
    end else begin
      pend <= 1'b0;
    end
  end
`else
  localparam int WARM = 2;
  assign s = sync[1];
`endif

  logic [WARM-1:0] warm;

  // prev is held at 1 until s reflects the pin, so a pin high at reset release is not a rise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      warm <= '0;
      prev <= 1'b1;
    end else begin
      warm <= {warm[WARM-2:0], 1'b1};
      prev <= warm[WARM-1] ? s : 1'b1;
    end
  end

  assign rise = s & ~prev;
  assign fall = ~s & prev;

endmodule

// File: rtl/pwm_capture.sv
// Measures period and high time of an external PWM input and flags a stuck pin.
// Optional glitch filter in pwm_sync enabled by PWM_CAPTURE_GLITCH_FILTER_EN.
module pwm_capture #(
  parameter int PWM_INTERVAL = pwm_pkg::PWM_INTERVAL,
  parameter int MAX_PERIOD   = 2 * PWM_INTERVAL,
  parameter int CW           = $clog2(MAX_PERIOD + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pwm_in,
  output logic [CW-1:0] period,
  output logic [CW-1:0] duty,
  output logic          valid,
  output logic          stuck,
  output logic          level
);

  import pwm_pkg::*;

  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_PERIOD);

  cap_state_t    state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] hcnt;
  logic          s;
  logic          rise;
  logic          fall;
  logic          at_max;

  pwm_sync u_sync (
    .clk    (clk),
    .rst    (rst),
    .pwm_in (pwm_in),
    .s      (s),
    .rise   (rise),
    .fall   (fall)
  );

  assign at_max = (cnt == CNT_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          cnt <= '0;
    else if (rise)    cnt <= CW'(1);
    else if (!at_max) cnt <= cnt + 1'b1;
  end

  // Timeout takes priority over any edge event except a rise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= WAIT;
      hcnt   <= '0;
      period <= '0;
      duty   <= '0;
      valid  <= 1'b0;
      stuck  <= 1'b0;
      level  <= 1'b0;
    end else begin
      valid <= 1'b0;
      level <= s;
      if (state != STUCK && at_max && !rise) begin
        state <= STUCK;
        stuck <= 1'b1;
      end else begin
        case (state)
          WAIT: if (rise) state <= HIGH;
          HIGH: if (fall) begin
            hcnt  <= cnt;
            state <= LOW;
          end
          LOW: if (rise) begin
            period <= cnt;
            duty   <= hcnt;
            valid  <= 1'b1;
            state  <= HIGH;
          end
          STUCK: if (rise) begin
            stuck <= 1'b0;
            state <= HIGH;
          end
          default: state <= WAIT;
        endcase
      end
    end
  end

endmodule
